cache_fill_arbiter: RTL and testbench

CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

---
 rtl/cache_fill_arbiter.sv | 167 ++++++++++++++++
 tb/tb_cache_fill_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_arbiter.sv
// Round-robin cache-line fill arbiter: grants one miss requester, streams a full line from memory.
// Optional build macro CACHE_FILL_CRITICAL_WORD_FIRST_EN starts each line at the missed word.
module cache_fill_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 16,
   parameter int WORDS_PER_LINE = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_REQ-1:0]                miss_req,
   input  logic [NUM_REQ*ADDR_W-1:0]         miss_addr,
   output logic [NUM_REQ-1:0]                fill_grant,
   output logic                              mem_rd,
   output logic [ADDR_W-1:0]                 mem_addr,
   input  logic [DATA_W-1:0]                 mem_rdata,
   input  logic                              mem_rvalid,
   output logic                              fill_valid,
   output logic [$clog2(WORDS_PER_LINE)-1:0] fill_word_idx,
   output logic [DATA_W-1:0]                 fill_data,
   output logic [NUM_REQ-1:0]                fill_done,
   output logic                              stall
);

   localparam int WIDX  = $clog2(WORDS_PER_LINE);
   localparam int CNT_W = WIDX + 1;
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [CNT_W-1:0]  LAST_WORD  = CNT_W'(WORDS_PER_LINE - 1);
   localparam logic [CNT_W-1:0]  FULL_LINE  = CNT_W'(WORDS_PER_LINE);
   localparam logic [ADDR_W-1:0] LINE_MASK  = ~((ADDR_W'(1'b1) << (WIDX + 1)) - ADDR_W'(1'b1));

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]         state_r,     state_n;
   logic [PTR_W-1:0]   ptr_r,       ptr_n;
   logic [NUM_REQ-1:0] owner_r,     owner_n;
   logic [ADDR_W-1:0]  base_r,      base_n;
   logic [WIDX-1:0]    start_idx_r, start_n;
   logic [CNT_W-1:0]   issue_cnt_r, issue_n;
   logic [CNT_W-1:0]   ret_cnt_r,   ret_n;

   logic [PTR_W-1:0]   pick_s;
   logic [ADDR_W-1:0]  sel_addr_s;
   logic [CNT_W-1:0]   outstanding_s;
   logic               accept_s;
   logic [WIDX-1:0]    issue_idx_s;
   logic [WIDX-1:0]    fill_idx_s;

   // First requesting index at or after the priority pointer, wrapping.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [PTR_W-1:0]   ptr);
      logic [PTR_W-1:0] pick;
      logic             found;
      int               idx;
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            pick  = PTR_W'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign pick_s        = rr_pick(miss_req, ptr_r);
   assign sel_addr_s    = miss_addr[int'(pick_s)*ADDR_W +: ADDR_W];
   assign outstanding_s = issue_cnt_r - ret_cnt_r;
   // Returns only count while a read of the current line is in flight; stale ones after reset fall out here.
   assign accept_s      = mem_rvalid && ((state_r == S_ISSUE) || (state_r == S_DRAIN))
                          && (outstanding_s != {CNT_W{1'b0}});
   assign issue_idx_s   = start_idx_r + issue_cnt_r[WIDX-1:0];
   assign fill_idx_s    = start_idx_r + ret_cnt_r[WIDX-1:0];

   assign fill_grant    = owner_r;
   assign mem_rd        = (state_r == S_ISSUE);
   assign mem_addr      = mem_rd ? (base_r | ADDR_W'({issue_idx_s, 1'b0})) : {ADDR_W{1'b0}};
   assign fill_valid    = accept_s;
   assign fill_word_idx = fill_idx_s;
   assign fill_data     = rst_n ? mem_rdata : {DATA_W{1'b0}};
   assign fill_done     = (state_r == S_DONE) ? owner_r : {NUM_REQ{1'b0}};
   assign stall         = rst_n & ((|miss_req) | (state_r != S_IDLE));

   // Next-state and datapath update for the fill sequencer.
   always_comb begin
      state_n = state_r;
      ptr_n   = ptr_r;
      owner_n = owner_r;
      base_n  = base_r;
      start_n = start_idx_r;
      issue_n = issue_cnt_r;
      ret_n   = ret_cnt_r + (accept_s ? CNT_W'(1'b1) : {CNT_W{1'b0}});
      case (state_r)
         S_IDLE: begin
            if (|miss_req) begin
               state_n = S_ISSUE;
               owner_n = NUM_REQ'(1'b1) << pick_s;
               ptr_n   = PTR_W'((int'(pick_s) + 1) % NUM_REQ);
               base_n  = sel_addr_s & LINE_MASK;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
               start_n = sel_addr_s[WIDX:1];
`else
               start_n = {WIDX{1'b0}};
`endif
               issue_n = {CNT_W{1'b0}};
               ret_n   = {CNT_W{1'b0}};
            end else begin
               state_n = S_IDLE;
            end
         end
         S_ISSUE: begin
            issue_n = issue_cnt_r + CNT_W'(1'b1);
            if (issue_cnt_r == LAST_WORD) begin
               if (ret_n == FULL_LINE) begin
                  state_n = S_DONE;
               end else begin
                  state_n = S_DRAIN;
               end
            end else begin
               state_n = S_ISSUE;
            end
         end
         S_DRAIN: begin
            if (ret_n == FULL_LINE) begin
               state_n = S_DONE;
            end else begin
               state_n = S_DRAIN;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
            owner_n = {NUM_REQ{1'b0}};
         end
         default: begin
            state_n = S_IDLE;
            owner_n = {NUM_REQ{1'b0}};
         end
      endcase
   end

   // State and datapath registers; reset drops any fill in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         ptr_r       <= {PTR_W{1'b0}};
         owner_r     <= {NUM_REQ{1'b0}};
         base_r      <= {ADDR_W{1'b0}};
         start_idx_r <= {WIDX{1'b0}};
         issue_cnt_r <= {CNT_W{1'b0}};
         ret_cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r     <= state_n;
         ptr_r       <= ptr_n;
         owner_r     <= owner_n;
         base_r      <= base_n;
         start_idx_r <= start_n;
         issue_cnt_r <= issue_n;
         ret_cnt_r   <= ret_n;
      end
   end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a fixed 4-cycle memory; honours CACHE_FILL_CRITICAL_WORD_FIRST_EN.
module tb_cache_fill_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  miss_req;
   logic [31:0] miss_addr;
   logic [1:0]  fill_grant;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [15:0] mem_rdata;
   logic        mem_rvalid;
   logic        fill_valid;
   logic [2:0]  fill_word_idx;
   logic [15:0] fill_data;
   logic [1:0]  fill_done;
   logic        stall;

   int checks   = 0;
   int failures = 0;

   cache_fill_arbiter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .miss_req      (miss_req),
      .miss_addr     (miss_addr),
      .fill_grant    (fill_grant),
      .mem_rd        (mem_rd),
      .mem_addr      (mem_addr),
      .mem_rdata     (mem_rdata),
      .mem_rvalid    (mem_rvalid),
      .fill_valid    (fill_valid),
      .fill_word_idx (fill_word_idx),
      .fill_data     (fill_data),
      .fill_done     (fill_done),
      .stall         (stall)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_data(input logic [15:0] a);
      return a ^ 16'h5A3C;
   endfunction

   // Memory returns each read exactly four cycles after it is issued.
   logic [3:0]  pipe_v = 4'b0000;
   logic [15:0] pipe_a [4];
   always @(posedge clk) begin
      pipe_v    <= {pipe_v[2:0], mem_rd};
      pipe_a[0] <= mem_addr;
      pipe_a[1] <= pipe_a[0];
      pipe_a[2] <= pipe_a[1];
      pipe_a[3] <= pipe_a[2];
   end
   assign mem_rvalid = pipe_v[3];
   assign mem_rdata  = pipe_v[3] ? mem_data(pipe_a[3]) : 16'h0000;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Follows one complete line fill for requester req, checking every issue, return and the done pulse.
   task automatic run_fill(input int req, input logic [15:0] addr, input int drop_after);
      logic [15:0] base;
      logic [2:0]  st;
      logic [2:0]  exp_idx;
      logic [1:0]  oh;
      int n_iss, n_ret, n_done, first_iss, last_iss, last_ret, done_cyc;
      base = addr & 16'hFFF0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      st = addr[3:1];
`else
      st = 3'd0;
`endif
      oh = 2'b01 << req;
      n_iss = 0; n_ret = 0; n_done = 0;
      first_iss = -1; last_iss = -1; last_ret = -1; done_cyc = -1;
      #1 check_eq("stall_req", stall, 1'b1);
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk);
         if (done_cyc >= 0) begin
            check_eq("done_once", fill_done, 2'b00);
            check_eq("grant_idle", fill_grant, 2'b00);
            break;
         end
         if (fill_grant != 2'b00) check_eq("grant", fill_grant, oh);
         if (n_iss > 0) check_eq("stall_busy", stall, 1'b1);
         if (mem_rd) begin
            check_eq("mem_addr", mem_addr, base + {st + 3'(n_iss), 1'b0});
            if (n_iss == 0) first_iss = cyc;
            last_iss = cyc;
            n_iss++;
            if (drop_after >= 0 && n_iss == drop_after) miss_req[req] = 1'b0;
         end
         if (fill_valid) begin
            exp_idx = st + 3'(n_ret);
            check_eq("fill_idx", fill_word_idx, exp_idx);
            check_eq("fill_data", fill_data, mem_data(base + {exp_idx, 1'b0}));
            last_ret = cyc;
            n_ret++;
         end
         if (fill_done != 2'b00) begin
            check_eq("fill_done", fill_done, oh);
            done_cyc = cyc;
            n_done++;
            miss_req[req] = 1'b0;
         end
      end
      check_eq("n_issue", n_iss, 8);
      check_eq("n_return", n_ret, 8);
      check_eq("n_done", n_done, 1);
      check_eq("issue_span", last_iss - first_iss, 7);
      check_eq("ret_latency", last_ret - last_iss, 4);
      check_eq("done_after_ret", done_cyc - last_ret, 1);
   endtask

   initial begin
      int n;
      clk       = 1'b0;
      rst_n     = 1'b0;
      miss_req  = 2'b00;
      miss_addr = 32'h0000_0000;
      repeat (3) @(negedge clk);
      check_eq("rst_grant", fill_grant, 2'b00);
      check_eq("rst_mem_rd", mem_rd, 1'b0);
      check_eq("rst_done", fill_done, 2'b00);
      check_eq("rst_stall", stall, 1'b0);
      check_eq("rst_fill_valid", fill_valid, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // Both request after reset: req0 wins; req0 re-raises as a new pair so req1 goes next.
      miss_addr = {16'h123A, 16'h4466};
      miss_req  = 2'b11;
      run_fill(0, 16'h4466, -1);
      miss_req[0] = 1'b1;
      run_fill(1, 16'h123A, -1);
      run_fill(0, 16'h4466, -1);

      miss_addr[15:0] = 16'h1234;
      miss_req        = 2'b01;
      run_fill(0, 16'h1234, -1);

      // Requester withdraws after three issues; the line still completes.
      miss_addr[31:16] = 16'h123A;
      miss_req         = 2'b10;
      run_fill(1, 16'h123A, 3);

      miss_addr[15:0] = 16'hBEEF;
      miss_req        = 2'b01;
      n = 0;
      for (int c = 0; c < 20 && n < 3; c++) begin
         @(negedge clk);
         if (mem_rd) n++;
      end
      check_eq("pre_reset_issues", n, 3);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_grant", fill_grant, 2'b00);
      check_eq("midrst_mem_rd", mem_rd, 1'b0);
      check_eq("midrst_stall", stall, 1'b0);
      check_eq("midrst_fill_valid", fill_valid, 1'b0);
      check_eq("midrst_done", fill_done, 2'b00);
      repeat (6) begin
         @(negedge clk);
         check_eq("midrst_hold_done", fill_done, 2'b00);
      end
      rst_n = 1'b1;
      run_fill(0, 16'hBEEF, -1);

      miss_req = 2'b00;
      repeat (3) @(negedge clk);
      check_eq("final_stall", stall, 1'b0);
      check_eq("final_grant", fill_grant, 2'b00);
      check_eq("final_mem_rd", mem_rd, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
